// File: rtl/reg_rd_port_arbiter_if.sv
// Register-file read-port bundle: requester handshakes, decoder select and read data.
// The master side is the requesters plus the register file; the slave side is the arbiter.
interface reg_rd_port_arbiter_if #(
  parameter int DATA_W = 16
) ();
  logic              req0;
  logic [3:0]        addr0;
  logic              req1;
  logic [3:0]        addr1;
  logic [3:0]        rd_op;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] data_out;
  logic              ack0;
  logic              ack1;
  logic              busy;

  modport master (
    output req0, addr0, req1, addr1, rd_data,
    input  rd_op, rd_en, data_out, ack0, ack1, busy
  );

  modport slave (
    input  req0, addr0, req1, addr1, rd_data,
    output rd_op, rd_en, data_out, ack0, ack1, busy
  );
endinterface

// File: rtl/reg_rd_port_arbiter.sv
// Round-robin arbiter sharing one register-file read port between two requesters;
// holds the decoder select for SETTLE_CYCLES edges, then captures data and acks.
module reg_rd_port_arbiter #(
  parameter int NAND_TIME     = 7,
  parameter int DATA_W        = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  reg_rd_port_arbiter_if.slave rp
);

  // NAND_TIME only describes the external decoder; the registered outputs carry no delay here.
  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("SETTLE_CYCLES must be in 1..15");
    end
    if (NAND_TIME < 0) begin : g_bad_nand
      $error("NAND_TIME must be non-negative");
    end
  endgenerate

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_op;
  logic              r_gnt;
  logic              r_ptr;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_data;
  logic              r_ack0;
  logic              r_ack1;

  state_t            w_state_next;
  logic [3:0]        w_op_next;
  logic              w_gnt_next;
  logic              w_ptr_next;
  logic [3:0]        w_cnt_next;
  logic [DATA_W-1:0] w_data_next;
  logic              w_ack0_next;
  logic              w_ack1_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_gnt   <= 1'b0;
      r_ptr   <= 1'b0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_op    <= w_op_next;
      r_gnt   <= w_gnt_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
      r_data  <= w_data_next;
      r_ack0  <= w_ack0_next;
      r_ack1  <= w_ack1_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_op_next    = r_op;
    w_gnt_next   = r_gnt;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    w_data_next  = r_data;
    w_ack0_next  = 1'b0;
    w_ack1_next  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Requester 0 wins when alone, or on a tie while the pointer favours it.
        if (rp.req0 && (!rp.req1 || !r_ptr)) begin
          w_op_next    = rp.addr0;
          w_gnt_next   = 1'b0;
          w_ptr_next   = 1'b1;
          w_cnt_next   = CNT_INIT;
          w_state_next = ST_SELECT;
        end else if (rp.req1) begin
          w_op_next    = rp.addr1;
          w_gnt_next   = 1'b1;
          w_ptr_next   = 1'b0;
          w_cnt_next   = CNT_INIT;
          w_state_next = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_next = r_cnt - 4'd1;
        end else begin
          w_data_next  = rp.rd_data;
          w_ack0_next  = !r_gnt;
          w_ack1_next  = r_gnt;
          w_state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign rp.rd_op    = r_op;
  assign rp.rd_en    = (r_state == ST_SELECT);
  assign rp.busy     = (r_state != ST_IDLE);
  assign rp.data_out = r_data;
  assign rp.ack0     = r_ack0;
  assign rp.ack1     = r_ack1;

endmodule
